// File: rtl/alu_result_display.sv
// Converts a captured ALU result to BCD with a serial double-dabble and shows it
// on a 4-digit multiplexed seven-segment display (active-low segments and anodes).
//
// state  | meaning
// IDLE   | waiting for start, display shows committed digits
// LOAD   | initialise converter from the captured result/flag/op
// SHIFT  | 8 shift-add-3 steps, one bit per cycle
// COMMIT | copy converted digits into the display shadow, pulse done
module alu_result_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    input  logic       flag,
    input  logic [1:0] op,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [3:0] DASH  = 4'd10;
    localparam logic [3:0] ELET  = 4'd11;
    localparam logic [3:0] BLANK = 4'd15;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t      state, stateNext;
    logic [2:0]  bitCnt;
    logic [7:0]  capResult;
    logic        capFlag;
    logic [1:0]  capOp;
    logic [7:0]  binMain, binRem;
    logic [11:0] bcdMain;
    logic [7:0]  bcdRem;
    logic [3:0]  shadow [4];
    logic [3:0]  newDigit [4];
    logic [CW-1:0] scanCnt;
    logic [1:0]  scanIdx;
    logic        scanEn;
    logic [3:0]  negLow;
    logic [11:0] adjMain, adjRem;

    function automatic logic [11:0] addThree(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            DASH:    glyph = 7'b0111111;
            ELET:    glyph = 7'b0000110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = LOAD;
            LOAD:    stateNext = SHIFT;
            SHIFT:   if (bitCnt == 3'd7) stateNext = COMMIT;
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == COMMIT);

    assign negLow  = ~capResult[3:0] + 4'd1;
    assign adjMain = addThree(bcdMain);
    assign adjRem  = addThree({4'd0, bcdRem});

    always_comb begin
        newDigit[3] = BLANK;
        newDigit[2] = bcdMain[11:8];
        newDigit[1] = bcdMain[7:4];
        newDigit[0] = bcdMain[3:0];
        if (capOp == 2'b01 && capFlag) begin
            newDigit[3] = DASH;
        end else if (capOp == 2'b11) begin
            if (capFlag) begin
                newDigit[3] = ELET;
                newDigit[2] = BLANK;
                newDigit[1] = BLANK;
                newDigit[0] = BLANK;
            end else begin
                newDigit[3] = bcdRem[7:4];
                newDigit[2] = bcdRem[3:0];
            end
        end
    end

    // Inputs are captured on the accepted start edge so later bus changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bitCnt    <= '0;
            capResult <= '0;
            capFlag   <= 1'b0;
            capOp     <= '0;
            binMain   <= '0;
            binRem    <= '0;
            bcdMain   <= '0;
            bcdRem    <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        capResult <= result;
                        capFlag   <= flag;
                        capOp     <= op;
                    end
                end
                LOAD: begin
                    bitCnt  <= '0;
                    bcdMain <= '0;
                    bcdRem  <= '0;
                    binRem  <= {4'd0, capResult[7:4]};
                    case (capOp)
                        2'b01:   binMain <= {4'd0, capFlag ? negLow : capResult[3:0]};
                        2'b11:   binMain <= {4'd0, capResult[3:0]};
                        default: binMain <= capResult;
                    endcase
                end
                SHIFT: begin
                    bcdMain <= {adjMain[10:0], binMain[7]};
                    bcdRem  <= {adjRem[6:0], binRem[7]};
                    binMain <= {binMain[6:0], 1'b0};
                    binRem  <= {binRem[6:0], 1'b0};
                    bitCnt  <= bitCnt + 3'd1;
                end
                COMMIT: begin
                    for (int i = 0; i < 4; i++) shadow[i] <= newDigit[i];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scanCnt <= '0;
            scanIdx <= '0;
            scanEn  <= 1'b0;
        end else begin
            scanEn <= 1'b1;
            if (scanCnt == CW'(REFRESH_DIV - 1)) begin
                scanCnt <= '0;
                scanIdx <= scanIdx + 2'd1;
            end else begin
                scanCnt <= scanCnt + 1'b1;
            end
        end
    end

    assign an  = scanEn ? ~(4'b0001 << scanIdx) : 4'hF;
    assign seg = scanEn ? glyph(shadow[scanIdx]) : 7'h7F;

endmodule
